// File: rtl/datapath_sequencer.sv
// Three-phase instruction sequencer (IDLE -> EXEC -> WB) driving an integer datapath.
// Optional macro SEQ_BACK_TO_BACK_EN lets a new instruction be accepted during WB.
module datapath_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    input  logic [15:0] imm,
    input  logic        N,
    input  logic        Z,
    input  logic        C,
    output logic        W_en,
    output logic [2:0]  W_Adr,
    output logic [2:0]  R_Adr,
    output logic [2:0]  S_Adr,
    output logic [3:0]  ALU_OP,
    output logic        S_Sel,
    output logic [15:0] DS,
    output logic        N_q,
    output logic        Z_q,
    output logic        C_q,
    output logic        done
);

    typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

    state_e      state_q;
    logic [15:1] hold_instr_q;
    logic [15:0] hold_imm_q;
    logic        ready_q;
    logic        w_en_q;
    logic        done_q;
    logic        skip_q;
    logic        n_q;
    logic        z_q;
    logic        c_q;
    logic        accept;
    logic        exec_skip;
    logic        unused_instr0;

    // Bit 0 of the instruction word is reserved and deliberately dropped.
    assign unused_instr0 = instr[0];

    assign accept    = instr_valid && ready_q;
    assign exec_skip = hold_instr_q[1] && !z_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            hold_instr_q <= '0;
            hold_imm_q   <= '0;
            ready_q      <= 1'b1;
            w_en_q       <= 1'b0;
            done_q       <= 1'b0;
            skip_q       <= 1'b0;
            n_q          <= 1'b0;
            z_q          <= 1'b0;
            c_q          <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        hold_instr_q <= instr[15:1];
                        hold_imm_q   <= imm;
                        ready_q      <= 1'b0;
                        state_q      <= StExec;
                    end
                end
                StExec: begin
                    skip_q  <= exec_skip;
                    w_en_q  <= !exec_skip;
                    done_q  <= 1'b1;
                    state_q <= StWb;
`ifdef SEQ_BACK_TO_BACK_EN
                    ready_q <= 1'b1;
`endif
                end
                StWb: begin
                    w_en_q <= 1'b0;
                    done_q <= 1'b0;
                    // A skipped conditional leaves the stored flags untouched.
                    if (!skip_q) begin
                        n_q <= N;
                        z_q <= Z;
                        c_q <= C;
                    end
`ifdef SEQ_BACK_TO_BACK_EN
                    if (accept) begin
                        hold_instr_q <= instr[15:1];
                        hold_imm_q   <= imm;
                        ready_q      <= 1'b0;
                        state_q      <= StExec;
                    end else begin
                        state_q      <= StIdle;
                    end
`else
                    ready_q <= 1'b1;
                    state_q <= StIdle;
`endif
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign instr_ready = ready_q;
    assign W_en        = w_en_q;
    assign done        = done_q;
    assign ALU_OP      = hold_instr_q[15:12];
    assign W_Adr       = hold_instr_q[11:9];
    assign R_Adr       = hold_instr_q[8:6];
    assign S_Adr       = hold_instr_q[5:3];
    assign S_Sel       = hold_instr_q[2];
    assign DS          = hold_imm_q;
    assign N_q         = n_q;
    assign Z_q         = z_q;
    assign C_q         = c_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench for datapath_sequencer: a driver pushes expected retirements,
// a negedge monitor pops and compares them against a flag/skip reference model.
module tb_datapath_sequencer;

`ifdef SEQ_BACK_TO_BACK_EN
    localparam int B2B = 1;
`else
    localparam int B2B = 0;
`endif

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  w;
        logic [2:0]  r;
        logic [2:0]  s;
        logic        ssel;
        logic        cond;
        logic [15:0] ds;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] imm;
    logic        N, Z, C;
    logic        W_en;
    logic [2:0]  W_Adr, R_Adr, S_Adr;
    logic [3:0]  ALU_OP;
    logic        S_Sel;
    logic [15:0] DS;
    logic        N_q, Z_q, C_q;
    logic        done;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    bit   mon_en = 0;
    bit   mn = 0, mz = 0, mc = 0;
    bit   fix_flags = 0;
    logic [2:0] fix_nzc = 3'b000;

    datapath_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .imm         (imm),
        .N           (N),
        .Z           (Z),
        .C           (C),
        .W_en        (W_en),
        .W_Adr       (W_Adr),
        .R_Adr       (R_Adr),
        .S_Adr       (S_Adr),
        .ALU_OP      (ALU_OP),
        .S_Sel       (S_Sel),
        .DS          (DS),
        .N_q         (N_q),
        .Z_q         (Z_q),
        .C_q         (C_q),
        .done        (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Flags change just after each rising edge so they are stable at the next one.
    initial begin
        {N, Z, C} = 3'b000;
        forever begin
            @(posedge clk);
            #2;
            if (fix_flags) {N, Z, C} = fix_nzc;
            else           {N, Z, C} = 3'($urandom);
        end
    end

    // Monitor: retirement on done, EXEC-cycle field check, stored-flag model every cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        bit   skip;
        if (mon_en) begin
            chk("stored_flags", 32'({N_q, Z_q, C_q}), 32'({mn, mz, mc}));
            if (done) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 expected no pending instruction");
                end else begin
                    e = q.pop_front();
                    skip = e.cond && !mz;
                    chk("wb_w_en", 32'(W_en), 32'(!skip));
                    chk("wb_fields", 32'({ALU_OP, W_Adr, R_Adr, S_Adr, S_Sel}),
                        32'({e.op, e.w, e.r, e.s, e.ssel}));
                    chk("wb_ds", 32'(DS), 32'(e.ds));
                    chk("wb_latency", 32'(cyc), 32'(e.acc + 1));
                    chk("wb_ready", 32'(instr_ready), 32'(B2B));
                    if (!skip) {mn, mz, mc} = {N, Z, C};
                end
            end else begin
                chk("w_en_without_done", 32'(W_en), 32'(0));
                if (q.size() > 0 && cyc == q[0].acc) begin
                    chk("exec_fields", 32'({ALU_OP, W_Adr, R_Adr, S_Adr, S_Sel}),
                        32'({q[0].op, q[0].w, q[0].r, q[0].s, q[0].ssel}));
                    chk("exec_ds", 32'(DS), 32'(q[0].ds));
                    chk("exec_ready", 32'(instr_ready), 32'(0));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one instruction and hold valid until accepted; returns the accept cycle.
    task automatic issue(input logic [15:0] ins, input logic [15:0] im, output int acc);
        exp_t e;
        bit   r;
        bit   ok;
        ok = 0;
        acc = -1;
        instr_valid = 1'b1;
        instr = ins;
        imm = im;
        for (int t = 0; t < 10 && !ok; t++) begin
            @(negedge clk);
            r = instr_ready;
            @(posedge clk);
            #1;
            if (r) ok = 1;
        end
        instr_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got no instr_ready expected accept within 10 cycles");
        end else begin
            e.op   = ins[15:12];
            e.w    = ins[11:9];
            e.r    = ins[8:6];
            e.s    = ins[5:3];
            e.ssel = ins[2];
            e.cond = ins[1];
            e.ds   = im;
            e.acc  = cyc;
            acc    = cyc;
            q.push_back(e);
        end
    endtask

    task automatic check_cleared(input string name);
        chk({name, "_ready"}, 32'(instr_ready), 32'(1));
        chk({name, "_ctrl"}, 32'({W_en, done, N_q, Z_q, C_q}), 32'(0));
        chk({name, "_fields"}, 32'({ALU_OP, W_Adr, R_Adr, S_Adr, S_Sel}), 32'(0));
        chk({name, "_ds"}, 32'(DS), 32'(0));
    endtask

    initial begin
        int acc;
        int prev;
        reset = 1'b1;
        instr_valid = 1'b0;
        instr = '0;
        imm = '0;
        idle(2);
        reset = 1'b0;
        @(negedge clk);
        check_cleared("reset_state");
        idle(1);
        mon_en = 1;

        // Directed: basic op, immediate operand, conditional skip then taken.
        fix_flags = 1;
        fix_nzc = 3'b000;
        issue(16'h2A50, 16'h0000, acc);
        issue(16'h1E04, 16'h00FF, acc);
        issue(16'h2A51, 16'h0000, acc);
        issue(16'h3202, 16'h0000, acc);
        fix_nzc = 3'b010;
        issue(16'h2A50, 16'h0000, acc);
        issue(16'h3202, 16'h1234, acc);
        idle(4);

        // Valid held high across a burst: fixed accept spacing, order preserved.
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            issue({4'hA, 3'(i + 3), 3'(i), 3'(7 - i), 3'b000}, 16'(i * 17), acc);
            if (prev >= 0) chk("burst_spacing", 32'(acc - prev), 32'(B2B ? 2 : 3));
            prev = acc;
        end
        idle(4);

        // Reset while the instruction is in EXEC: nothing may retire.
        fix_nzc = 3'b111;
        issue(16'h2A50, 16'h0000, acc);
        mon_en = 0;
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        q.delete();
        {mn, mz, mc} = 3'b000;
        @(negedge clk);
        check_cleared("reset_in_exec");
        idle(1);
        @(negedge clk);
        chk("no_done_after_reset", 32'({W_en, done}), 32'(0));
        idle(1);

        // Reset dominates a simultaneous valid in IDLE.
        reset = 1'b1;
        instr_valid = 1'b1;
        instr = 16'hFFFE;
        imm = 16'hBEEF;
        idle(1);
        reset = 1'b0;
        instr_valid = 1'b0;
        @(negedge clk);
        check_cleared("reset_vs_valid");
        idle(1);
        mon_en = 1;

        // Randomized traffic with random flags and gaps.
        fix_flags = 0;
        for (int i = 0; i < 40; i++) begin
            idle(int'($urandom_range(0, 2)));
            issue(16'($urandom), 16'($urandom), acc);
        end
        idle(6);
        chk("queue_drained", 32'(q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/datapath_sequencer.md
DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 Parameters: none.
REQ-002 Single clock domain; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 instr_valid  in  1  upstream instruction present.
REQ-006 instr_ready  out  1  sequencer accepts instruction this cycle.
REQ-007 instr  in  16  [15:12] ALU_OP, [11:9] W_Adr, [8:6] R_Adr, [5:3] S_Adr, [2] S_Sel, [1] cond, [0] reserved (ignored).
REQ-008 imm  in  16  immediate, captured with instr.
REQ-009 N, Z, C  in  1 each  flags from integer datapath ALU.
REQ-010 W_en  out  1  register-file write enable to datapath.
REQ-011 W_Adr, R_Adr, S_Adr  out  3 each  register addresses to datapath.
REQ-012 ALU_OP  out  4  ALU operation to datapath.
REQ-013 S_Sel  out  1  1 selects DS as ALU S operand.
REQ-014 DS  out  16  immediate operand to datapath.
REQ-015 N_q, Z_q, C_q  out  1 each  stored status flags.
REQ-016 done  out  1  one-cycle pulse on instruction retire or skip.

Function
REQ-017 States: IDLE, EXEC, WB; all outputs registered.
REQ-018 IDLE: instr_ready=1; on instr_valid&&instr_ready capture instr and imm into holding register, go EXEC.
REQ-019 EXEC (one cycle): W_Adr/R_Adr/S_Adr/ALU_OP/S_Sel/DS driven from holding register; W_en=0; go WB.
REQ-020 WB (one cycle): fields held, W_en=1 unless skipped; flags N/Z/C sampled into N_q/Z_q/C_q at end of WB unless skipped; done=1; go IDLE.
REQ-021 Skip: cond=1 and Z_q=0 at EXEC -> in WB W_en=0, flags unchanged, done still pulses.
REQ-022 Latency: accept at edge k -> EXEC cycle k+1, WB cycle k+2, IDLE k+3; throughput one instruction per 3 cycles.
REQ-023 Address/opcode/DS outputs hold last value in IDLE; W_en=0 in IDLE and EXEC always.
REQ-024 instr_valid ignored when instr_ready=0; no buffering beyond holding register.
REQ-025 instr[0] has no effect on any output.

Reset
REQ-026 reset sampled high -> next edge: state IDLE, instr_ready=1, W_en=0, done=0, all address/ALU_OP/S_Sel/DS=0, N_q=Z_q=C_q=0, holding register cleared.
REQ-027 Reset mid-EXEC or mid-WB aborts instruction; no W_en pulse, no flag update, no done after reset edge.
REQ-028 Reset dominates simultaneous instr_valid.

Configuration
REQ-029 Macro SEQ_BACK_TO_BACK_EN.
REQ-030 Defined: instr_ready=1 also in WB; accept in WB -> next state EXEC with new holding contents, throughput one per 2 cycles; flags from retiring instruction still stored and visible to new instruction's cond check.
REQ-031 Undefined: instr_ready=1 only in IDLE per REQ-018/022.

Verification
REQ-032 instr=0x2A50 (ALU_OP=2,W=5,R=1,S=2,S_Sel=0), valid 1 cycle -> EXEC next cycle, W_en=1 with W_Adr=5 exactly one cycle later, done with it, instr_ready low 2 cycles.
REQ-033 instr=0x1E04, imm=0x00FF -> S_Sel=1, DS=0x00FF, W_Adr=7 in EXEC/WB.
REQ-034 Z=0 during first WB, then cond instr 0x3202 -> W_en stays 0, done=1, Z_q unchanged; repeat after Z=1 stored -> W_en=1.
REQ-035 reset asserted in EXEC -> no W_en pulse, all outputs zero, instr_ready=1 next cycle.
REQ-036 valid held high with 4 instructions -> accepts every 3 cycles (every 2 with SEQ_BACK_TO_BACK_EN), W_Adr order preserved, no lost or duplicated W_en.
